// File: rtl/dmem_access_ctrl_if.sv
// Data-memory bus between the load/store access controller and a variable-latency memory.
// The controller drives request, address, byte enables and write data; memory answers with ack, read data and error.
interface dmem_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata,
        input  bus_err
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata,
        output bus_err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences RV32I loads/stores from a single-cycle datapath onto a req/ack data bus.
// The datapath is stalled until the access completes; faults are reported in the single DONE cycle.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_read_i,
    input  logic                       mem_write_i,
    input  logic [2:0]                 funct3_i,
    input  logic [31:0]                addr_i,
    input  logic [31:0]                wdata_i,
    output logic                       stall_o,
    output logic [31:0]                rdata_o,
    output logic                       rdata_valid_o,
    output logic                       acc_fault_o,
    output logic                       misaligned_o,
    dmem_access_ctrl_if.master         bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        misal_q, misal_d;
    logic [31:0] rdata_q, rdata_d;

    logic        access;
    logic        req_illegal;
    logic        req_misal;
    logic        stall_c;
    logic [31:0] lane;
    logic [31:0] load_ext;

    assign access = mem_read_i | mem_write_i;

    // Alignment is only judged for a legal encoding, so misaligned never qualifies an illegal-op fault.
    always_comb begin
        req_illegal = 1'b0;
        req_misal   = 1'b0;
        if (mem_read_i && mem_write_i) begin
            req_illegal = 1'b1;
        end else if (mem_write_i) begin
            req_illegal = funct3_i[2] | (funct3_i[1:0] == 2'b11);
        end else begin
            req_illegal = (funct3_i == 3'b011) | (funct3_i == 3'b110) | (funct3_i == 3'b111);
        end
        if (!req_illegal) begin
            case (funct3_i[1:0])
                2'b01:   req_misal = addr_i[0];
                2'b10:   req_misal = (addr_i[1:0] != 2'b00);
                default: req_misal = 1'b0;
            endcase
        end
    end

    assign lane = bus.bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_ext = lane;
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_ext = {24'h000000, lane[7:0]};
            3'b101:  load_ext = {16'h0000, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        misal_d  = misal_q;
        rdata_d  = rdata_q;
        stall_c  = 1'b0;

        case (state_q)
            IDLE: begin
                stall_c = access;
                if (access) begin
                    addr_d   = addr_i;
                    funct3_d = funct3_i;
                    we_d     = mem_write_i;
                    wdata_d  = wdata_i;
                    cnt_d    = 8'd1;
                    fault_d  = 1'b0;
                    misal_d  = 1'b0;
                    if (req_illegal || req_misal) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        misal_d = req_misal;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_c = 1'b1;
                // An ack arriving in the final allowed cycle still wins over the timeout.
                if (bus.bus_ack) begin
                    state_d = DONE;
                    if (bus.bus_err) begin
                        fault_d = 1'b1;
                    end else if (!we_q) begin
                        rdata_d = load_ext;
                    end
                end else if (cnt_q == TIMEOUT_CNT) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            we_q     <= 1'b0;
            wdata_q  <= 32'h0;
            cnt_q    <= 8'd0;
            fault_q  <= 1'b0;
            misal_q  <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            misal_q  <= misal_d;
            rdata_q  <= rdata_d;
        end
    end

    // IDLE stall follows the decode inputs combinationally, so it must be masked while in reset.
    assign stall_o       = rst_n & stall_c;
    assign acc_fault_o   = (state_q == DONE) & fault_q;
    assign misaligned_o  = (state_q == DONE) & misal_q;
    assign rdata_valid_o = (state_q == DONE) & ~fault_q & ~we_q;
    assign rdata_o       = acc_fault_o ? 32'h0 : rdata_q;

    assign bus.bus_req  = (state_q == REQ);
    assign bus.bus_we   = we_q;
    assign bus.bus_addr = {addr_q[31:2], 2'b00};

    always_comb begin
        bus.bus_be    = 4'b1111;
        bus.bus_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                bus.bus_be    = 4'b0001 << addr_q[1:0];
                bus.bus_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                bus.bus_be    = 4'b0011 << {addr_q[1], 1'b0};
                bus.bus_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                bus.bus_be    = 4'b1111;
                bus.bus_wdata = wdata_q;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: each access is driven until the stall releases,
// then the DONE-cycle outputs and first-REQ-cycle bus signals are compared with hand-computed values.
module tb_dmem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        acc_fault;
    logic        misaligned;

    int checkCount;
    int passCount;

    int          stallCnt;
    int          reqCnt;
    logic        gotDone;
    logic        doneFault;
    logic        doneMis;
    logic        doneValid;
    logic [31:0] doneRdata;
    logic        obsWe;
    logic [31:0] obsAddr;
    logic [3:0]  obsBe;
    logic [31:0] obsWdata;

    dmem_access_ctrl_if busIf ();

    dmem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_read_i    (mem_read),
        .mem_write_i   (mem_write),
        .funct3_i      (funct3),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .stall_o       (stall),
        .rdata_o       (rdata),
        .rdata_valid_o (rdata_valid),
        .acc_fault_o   (acc_fault),
        .misaligned_o  (misaligned),
        .bus           (busIf.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge with the controller in IDLE; returns just after the edge into the next IDLE.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int ackAt, input logic err, input logic [31:0] brd);
        mem_read        = rd;
        mem_write       = wr;
        funct3          = f3;
        addr            = a;
        wdata           = wd;
        busIf.bus_rdata = brd;
        stallCnt = 0;
        reqCnt   = 0;
        gotDone  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (!stall) begin
                gotDone   = 1'b1;
                doneFault = acc_fault;
                doneMis   = misaligned;
                doneValid = rdata_valid;
                doneRdata = rdata;
                break;
            end
            stallCnt++;
            if (busIf.bus_req) begin
                reqCnt++;
                if (reqCnt == 1) begin
                    obsWe    = busIf.bus_we;
                    obsAddr  = busIf.bus_addr;
                    obsBe    = busIf.bus_be;
                    obsWdata = busIf.bus_wdata;
                end
                if (reqCnt == ackAt) begin
                    busIf.bus_ack = 1'b1;
                    busIf.bus_err = err;
                end
            end
            @(posedge clk);
            #1;
            busIf.bus_ack = 1'b0;
            busIf.bus_err = 1'b0;
        end
        checkOutput("access_completes", {31'b0, gotDone}, 32'd1);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount      = 0;
        passCount       = 0;
        rst_n           = 1'b0;
        mem_read        = 1'b1;
        mem_write       = 1'b0;
        funct3          = 3'b010;
        addr            = 32'h0;
        wdata           = 32'h0;
        busIf.bus_ack   = 1'b0;
        busIf.bus_err   = 1'b0;
        busIf.bus_rdata = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_bus_req", {31'b0, busIf.bus_req}, 32'd0);
        checkOutput("rst_fault", {31'b0, acc_fault}, 32'd0);
        checkOutput("rst_rdata_valid", {31'b0, rdata_valid}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'h0);
        mem_read = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // LW 0x100, ack on the third request cycle
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b0, 32'hDEADBEEF);
        checkOutput("lw_stall_cycles", stallCnt, 32'd4);
        checkOutput("lw_req_cycles", reqCnt, 32'd3);
        checkOutput("lw_bus_addr", obsAddr, 32'h100);
        checkOutput("lw_bus_be", {28'b0, obsBe}, 32'hF);
        checkOutput("lw_bus_we", {31'b0, obsWe}, 32'd0);
        checkOutput("lw_valid", {31'b0, doneValid}, 32'd1);
        checkOutput("lw_fault", {31'b0, doneFault}, 32'd0);
        checkOutput("lw_rdata", doneRdata, 32'hDEADBEEF);

        // Sub-word loads with sign and zero extension
        applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 1'b0, 32'h80FF0000);
        checkOutput("lb_be", {28'b0, obsBe}, 32'h8);
        checkOutput("lb_stall_cycles", stallCnt, 32'd2);
        checkOutput("lb_rdata", doneRdata, 32'hFFFFFF80);
        applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 1'b0, 32'h80FF0000);
        checkOutput("lbu_rdata", doneRdata, 32'h00000080);
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 1'b0, 32'h80FF0000);
        checkOutput("lh_be", {28'b0, obsBe}, 32'hC);
        checkOutput("lh_rdata", doneRdata, 32'hFFFF80FF);
        checkOutput("lh_valid", {31'b0, doneValid}, 32'd1);

        // SH 0x202, immediate ack; rdata keeps the previous load result
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 1'b0, 32'h0);
        checkOutput("sh_we", {31'b0, obsWe}, 32'd1);
        checkOutput("sh_addr", obsAddr, 32'h200);
        checkOutput("sh_be", {28'b0, obsBe}, 32'hC);
        checkOutput("sh_wdata", obsWdata, 32'hABCDABCD);
        checkOutput("sh_valid", {31'b0, doneValid}, 32'd0);
        checkOutput("sh_fault", {31'b0, doneFault}, 32'd0);
        checkOutput("sh_rdata_held", doneRdata, 32'hFFFF80FF);

        // SB replicates the byte into every lane
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h001, 32'h000000A5, 1, 1'b0, 32'h0);
        checkOutput("sb_be", {28'b0, obsBe}, 32'h2);
        checkOutput("sb_wdata", obsWdata, 32'hA5A5A5A5);

        // Misaligned LW never reaches the bus
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 1'b0, 32'h0);
        checkOutput("mis_req_cycles", reqCnt, 32'd0);
        checkOutput("mis_stall_cycles", stallCnt, 32'd1);
        checkOutput("mis_fault", {31'b0, doneFault}, 32'd1);
        checkOutput("mis_flag", {31'b0, doneMis}, 32'd1);
        checkOutput("mis_valid", {31'b0, doneValid}, 32'd0);
        checkOutput("mis_rdata", doneRdata, 32'h0);

        // Timeout with TIMEOUT=4
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 1'b0, 32'h0);
        checkOutput("to_req_cycles", reqCnt, 32'd4);
        checkOutput("to_stall_cycles", stallCnt, 32'd5);
        checkOutput("to_fault", {31'b0, doneFault}, 32'd1);
        checkOutput("to_mis", {31'b0, doneMis}, 32'd0);
        checkOutput("to_valid", {31'b0, doneValid}, 32'd0);

        // Bus error response
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1, 1'b1, 32'h12345678);
        checkOutput("err_req_cycles", reqCnt, 32'd1);
        checkOutput("err_fault", {31'b0, doneFault}, 32'd1);
        checkOutput("err_mis", {31'b0, doneMis}, 32'd0);
        checkOutput("err_valid", {31'b0, doneValid}, 32'd0);
        checkOutput("err_rdata", doneRdata, 32'h0);

        // Illegal encodings
        applyStimulus(1'b0, 1'b1, 3'b011, 32'h0, 32'h0, 1, 1'b0, 32'h0);
        checkOutput("ill_store_fault", {31'b0, doneFault}, 32'd1);
        checkOutput("ill_store_mis", {31'b0, doneMis}, 32'd0);
        checkOutput("ill_store_req", reqCnt, 32'd0);
        applyStimulus(1'b1, 1'b0, 3'b110, 32'h0, 32'h0, 1, 1'b0, 32'h0);
        checkOutput("ill_load_fault", {31'b0, doneFault}, 32'd1);
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 1, 1'b0, 32'h0);
        checkOutput("ill_rdwr_fault", {31'b0, doneFault}, 32'd1);
        checkOutput("ill_rdwr_req", reqCnt, 32'd0);

        // Reset asserted in the second request cycle
        mem_read = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h500;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("rstreq_req_before", {31'b0, busIf.bus_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstreq_req_after", {31'b0, busIf.bus_req}, 32'd0);
        checkOutput("rstreq_stall_after", {31'b0, stall}, 32'd0);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back SW then LW at minimum latency
        applyStimulus(1'b0, 1'b1, 3'b010, 32'h400, 32'h11223344, 1, 1'b0, 32'h0);
        checkOutput("b2b_sw_stall", stallCnt, 32'd2);
        checkOutput("b2b_sw_wdata", obsWdata, 32'h11223344);
        checkOutput("b2b_sw_be", {28'b0, obsBe}, 32'hF);
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1, 1'b0, 32'h11223344);
        checkOutput("b2b_lw_stall", stallCnt, 32'd2);
        checkOutput("b2b_lw_valid", {31'b0, doneValid}, 32'd1);
        checkOutput("b2b_lw_rdata", doneRdata, 32'h11223344);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
